// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Tag builder is written for ids up to 8 bits and payloads up to 64 bits.
    localparam int unsigned TAG_ID_W   = 8;
    localparam int unsigned TAG_DATA_W = 64;
    localparam int unsigned TAG_W      = TAG_ID_W + 1 + TAG_DATA_W;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic logic [TAG_W-1:0] build_wdata(input logic [TAG_ID_W-1:0]   id,
                                                     input logic                  last,
                                                     input logic [TAG_DATA_W-1:0] data,
                                                     input int unsigned           data_width);
        return (TAG_W'(id) << (data_width + 32'd1)) | (TAG_W'(last) << data_width) | TAG_W'(data);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first eligible requester at or above rr_ptr, wrapping around.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    localparam int unsigned DW2 = 2 * N;

    logic [DW2-1:0] dbl;
    logic [DW2-1:0] masked;

    // Upper copy guarantees a hit below rr_ptr once the lower copy is masked off.
    always_comb begin
        dbl    = {eligible, eligible};
        masked = dbl & ~((DW2'(1) << rr_ptr) - DW2'(1));
        found  = |eligible;
        index  = '0;
        for (int i = int'(DW2) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                index = (i >= int'(N)) ? IW'(i - int'(N)) : IW'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one async FIFO write port among requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned MAX_BEATS  = 16,
    localparam int unsigned ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_en,
    output logic                            fifo_wen,
    output logic [ID_WIDTH+DATA_WIDTH:0]    fifo_wdata,
    input  logic                            fifo_wfull,
    output logic                            busy,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic                            err_overlong
);

    localparam int unsigned CNT_WIDTH = id_width(MAX_BEATS);
    localparam int unsigned FW        = ID_WIDTH + 1 + DATA_WIDTH;

    state_t                  state;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [CNT_WIDTH-1:0]    beat_cnt;
    logic [NUM_REQ-1:0]      eligible;
    logic                    pick_found;
    logic [ID_WIDTH-1:0]     pick_idx;
    logic                    gnt_valid;
    logic                    gnt_last;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic                    last_out;

    assign eligible = req_valid & req_en;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_WIDTH)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .index    (pick_idx)
    );

    // Granted requester's beat goes straight through; a full FIFO stalls both sides.
    always_comb begin
        gnt_valid = req_valid[grant_id];
        gnt_last  = req_last[grant_id];
        gnt_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        last_out  = gnt_last | (beat_cnt == CNT_WIDTH'(MAX_BEATS - 1));
        req_ready = '0;
        fifo_wen  = 1'b0;
        if (state == BURST && !fifo_wfull) begin
            req_ready[grant_id] = 1'b1;
            fifo_wen            = gnt_valid;
        end
        fifo_wdata = FW'(build_wdata(TAG_ID_W'(grant_id), last_out,
                                     TAG_DATA_W'(gnt_data), DATA_WIDTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            beat_cnt     <= '0;
            err_overlong <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (fifo_wen) begin
                        if (last_out) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            beat_cnt <= '0;
                            rr_ptr   <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                             : grant_id + ID_WIDTH'(1);
                            // Truncated packet: remaining beats re-arbitrate as a new packet.
                            if (!gnt_last) begin
                                err_overlong <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences, random vs. model.
module tb_fifo_wr_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXB = 4;
    localparam int unsigned IW   = 2;
    localparam int unsigned FW   = IW + 1 + DW;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_en;
    logic              fifo_wen;
    logic [FW-1:0]     fifo_wdata;
    logic              fifo_wfull;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic              err_overlong;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .req_en       (req_en),
        .fifo_wen     (fifo_wen),
        .fifo_wdata   (fifo_wdata),
        .fifo_wfull   (fifo_wfull),
        .busy         (busy),
        .grant_id     (grant_id),
        .err_overlong (err_overlong)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: who holds the grant, next scan start, beats sent, sticky error.
    int m_busy, m_gid, m_ptr, m_cnt, m_err;

    logic [8:0]    src_q [N][$];
    logic [FW-1:0] wlog [$];
    logic [N-1:0]  gate;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        wen;
        logic [3:0]  ready;
        logic [10:0] wdata;
        logic        busy;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < int'(N); i++) begin
            if (src_q[i].size() > 0 && gate[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_q[i][0][7:0];
                req_last[i]           = src_q[i][0][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = 8'h00;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic load_pkt(input int r, input int base, input int len);
        for (int k = 0; k < len; k++) begin
            src_q[r].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'(base + k)});
        end
    endtask

    // One clock: check DUT against the model, advance the model, pop accepted beats.
    task automatic step();
        int   nb, ng, np, nc, ne, ewd;
        logic lo, ew;
        logic [3:0] er, acc;
        bit   hit;
        if (reset) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        end
        #1;
        lo  = req_last[m_gid] || (m_cnt == int'(MAXB) - 1);
        er  = (m_busy != 0 && !fifo_wfull) ? 4'(1 << m_gid) : 4'b0000;
        ew  = (m_busy != 0) && req_valid[m_gid] && !fifo_wfull;
        ewd = m_gid * 512 + (lo ? 256 : 0) + int'(req_data[m_gid*DW +: DW]);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("fifo_wen", 32'(fifo_wen), 32'(ew));
        if (ew) chk("fifo_wdata", 32'(fifo_wdata), 32'(ewd));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("err_overlong", 32'(err_overlong), 32'(m_err));
        if (fifo_wen) wlog.push_back(fifo_wdata);
        acc = req_valid & req_ready;
        nb = m_busy; ng = m_gid; np = m_ptr; nc = m_cnt; ne = m_err; hit = 0;
        if (reset) begin
            nb = 0; ng = 0; np = 0; nc = 0; ne = 0;
        end else if (m_busy == 0) begin
            for (int k = 0; k < int'(N); k++) begin
                int j;
                j = (m_ptr + k) % int'(N);
                if (!hit && req_valid[j] && req_en[j]) begin
                    hit = 1; ng = j; nb = 1;
                end
            end
        end else if (ew) begin
            if (lo) begin
                nb = 0; nc = 0; np = (m_gid + 1) % int'(N);
                if (!req_last[m_gid]) ne = 1;
            end else begin
                nc = m_cnt + 1;
            end
        end
        @(posedge clk);
        m_busy = nb; m_gid = ng; m_ptr = np; m_cnt = nc; m_err = ne;
        if (!reset) begin
            for (int i = 0; i < int'(N); i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive_srcs();
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < int'(N); i++) src_q[i].delete();
        gate       = '1;
        req_en     = '1;
        fifo_wfull = 1'b0;
        drive_srcs();
        step();
        step();
        reset = 1'b0;
        wlog.delete();
    endtask

    initial begin
        int cnt1, cnt2;
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        req_en     = '1;
        fifo_wfull = 1'b0;
        gate       = '1;
        m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        @(negedge clk);

        // Vector table: single 3-beat packet from req 2, then rr_ptr follow-on grants.
        tbl[0] = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0000, 11'h000, 1'b0, 2'd0};
        tbl[1] = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b1, 4'b0100, 11'h4A1, 1'b1, 2'd2};
        tbl[2] = '{4'b0100, 4'b0000, 32'h00A2_0000, 1'b1, 4'b0100, 11'h4A2, 1'b1, 2'd2};
        tbl[3] = '{4'b0100, 4'b0100, 32'h00A3_0000, 1'b1, 4'b0100, 11'h5A3, 1'b1, 2'd2};
        tbl[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 11'h000, 1'b0, 2'd2};
        tbl[5] = '{4'b1111, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 11'h000, 1'b0, 2'd2};
        tbl[6] = '{4'b1111, 4'b1111, 32'h4433_2211, 1'b1, 4'b1000, 11'h744, 1'b1, 2'd3};
        tbl[7] = '{4'b1111, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 11'h000, 1'b0, 2'd3};
        tbl[8] = '{4'b1111, 4'b1111, 32'h4433_2211, 1'b1, 4'b0001, 11'h111, 1'b1, 2'd0};

        do_reset();
        for (int r = 0; r < 9; r++) begin
            req_valid = tbl[r].valid;
            req_last  = tbl[r].last;
            req_data  = tbl[r].data;
            #1;
            chk($sformatf("tbl%0d_wen", r), 32'(fifo_wen), 32'(tbl[r].wen));
            chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
            if (tbl[r].wen) chk($sformatf("tbl%0d_wdata", r), 32'(fifo_wdata), 32'(tbl[r].wdata));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
            chk($sformatf("tbl%0d_gid", r), 32'(grant_id), 32'(tbl[r].gid));
            step();
        end

        // Fairness: everyone streaming single-beat packets from reset.
        do_reset();
        for (int i = 0; i < int'(N); i++) begin
            for (int p = 0; p < 3; p++) load_pkt(i, 16 * i + p, 1);
        end
        run(16);
        chk("fair_count", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++)
            chk($sformatf("fair_id%0d", i), 32'(wlog[i][10:9]), 32'(i % 4));

        // Backpressure during cycles 2-5 of a 4-beat packet from req 1.
        do_reset();
        load_pkt(1, 'hB0, 4);
        for (int c = 0; c < 12; c++) begin
            fifo_wfull = (c >= 2 && c <= 5);
            drive_srcs();
            step();
        end
        fifo_wfull = 1'b0;
        chk("bp_count", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk($sformatf("bp_beat%0d", i), 32'(wlog[i]), 32'(512 + (i == 3 ? 256 : 0) + 'hB0 + i));

        // Overlong: 6 beats from req 0 with MAX_BEATS=4.
        do_reset();
        load_pkt(0, 'hC0, 6);
        run(10);
        chk("ovl_count", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6 && i < wlog.size(); i++)
            chk($sformatf("ovl_beat%0d", i), 32'(wlog[i]), 32'(((i == 3 || i == 5) ? 256 : 0) + 'hC0 + i));
        chk("ovl_err", 32'(err_overlong), 32'd1);

        // Mask: req 1 disabled never wins.
        do_reset();
        req_en = 4'b1101;
        for (int p = 0; p < 3; p++) begin
            load_pkt(1, 'h10 + p, 1);
            load_pkt(2, 'h20 + p, 1);
        end
        run(16);
        cnt1 = 0; cnt2 = 0;
        foreach (wlog[i]) begin
            if (wlog[i][10:9] == 2'd1) cnt1++;
            if (wlog[i][10:9] == 2'd2) cnt2++;
        end
        chk("mask_req1_writes", 32'(cnt1), 32'd0);
        chk("mask_req2_writes", 32'(cnt2), 32'd3);

        // Mid-packet disable of req 3 does not abort its packet.
        do_reset();
        load_pkt(3, 'hD0, 4);
        for (int c = 0; c < 8; c++) begin
            if (c == 2) req_en[3] = 1'b0;
            drive_srcs();
            step();
        end
        req_en = '1;
        chk("dis_count", 32'(wlog.size()), 32'd4);
        foreach (wlog[i]) chk($sformatf("dis_id%0d", i), 32'(wlog[i][10:9]), 32'd3);
        chk("dis_err", 32'(err_overlong), 32'd0);

        // Reset during beat 2 of 4, after rr_ptr had moved to 3.
        do_reset();
        load_pkt(2, 'hE0, 1);
        run(3);
        load_pkt(0, 'hF0, 4);
        run(2);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        drive_srcs();
        #1;
        chk("rst_wen", 32'(fifo_wen), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < int'(N); i++) src_q[i].delete();
        load_pkt(1, 'h51, 1);
        load_pkt(3, 'h53, 1);
        wlog.delete();
        run(6);
        chk("rst_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("rst_first_id", 32'(wlog[0][10:9]), 32'd1);
            chk("rst_second_id", 32'(wlog[1][10:9]), 32'd3);
        end

        // Random traffic, backpressure and enable churn against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (src_q[i].size() == 0 && $urandom_range(3) == 0)
                    load_pkt(i, int'($urandom_range(255)), int'($urandom_range(6, 1)));
            end
            gate       = 4'($urandom);
            fifo_wfull = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) req_en = 4'($urandom);
            drive_srcs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, packet-locked arbiter that shares the write port of one async FIFO among NUM_REQ requesters in the FIFO's write clock domain. Each granted packet is forwarded beat by beat. Every beat is tagged with the source ID and a last flag, so the read side can demultiplex. Backpressure comes from the FIFO's full flag. The arbiter enforces a maximum packet length.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, payload bits per beat
- MAX_BEATS, 16, maximum beats per grant before forced release (>=1)
- ID_WIDTH (localparam), max(1, clog2(NUM_REQ)), source tag width

Ports:
- clk  in  1  write-domain clock (FIFO wclk)
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  final beat of packet
- req_ready  out  NUM_REQ  beat accepted when valid&ready
- req_en  in  NUM_REQ  eligibility mask for new grants
- fifo_wen  out  1  FIFO write enable
- fifo_wdata  out  ID_WIDTH+1+DATA_WIDTH  {id, last, data}
- fifo_wfull  in  1  FIFO full (write domain)
- busy  out  1  grant held (state BURST)
- grant_id  out  ID_WIDTH  currently or last granted requester
- err_overlong  out  1  sticky: a packet was truncated at MAX_BEATS

Behaviour:
- Clock and reset: clk, reset asynchronous active-high.
- Reset values: state IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, err_overlong=0, busy=0. req_ready=0 and fifo_wen=0 while in reset and in IDLE.
- FSM IDLE:
  - eligible = req_valid & req_en.
  - If eligible≠0, pick the first set bit scanning cyclically from rr_ptr upward.
  - Register grant_id and go to BURST. Arbitration costs one cycle; no beat is accepted in IDLE.
- FSM BURST:
  - req_ready[grant_id] = ~fifo_wfull; all other req_ready bits = 0 (combinational).
  - fifo_wen = req_valid[grant_id] & ~fifo_wfull; a write is accepted on the same edge.
  - fifo_wdata = {grant_id, last_out, req_data[grant_id]}.
  - last_out = req_last[grant_id] | (beat_cnt == MAX_BEATS-1).
- Beat counting: beat_cnt increments on each accepted beat and clears on release.
- Release: on an accepted beat with last_out=1:
  - go to IDLE, set rr_ptr = grant_id+1 (mod NUM_REQ), clear beat_cnt.
  - If req_last was 0, set err_overlong. It stays set until reset. The requester's remaining beats form a new packet through normal arbitration.
- Stall rules:
  - fifo_wfull=1 stalls with no write and no state change.
  - A deasserted req_valid mid-packet holds the grant indefinitely.
- Enable mask: deasserting req_en mid-packet does not abort the grant; it only affects the next arbitration.
- Throughput: best case is a 1-cycle bubble between packets; a single-beat packet takes 2 cycles.
- Reset mid-packet: immediate return to IDLE. Partial packet already in the FIFO is not recalled.
- grant_id holds its value in IDLE.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum (IDLE, BURST)
  - function for ID_WIDTH
  - function building the fifo_wdata tag
- One sub-module rr_pick: combinational round-robin priority selector.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: found, index.
  - Implemented as double-width mask-and-priority.

Test Plan:
- Single request: req 2 sends 3 beats (0xA1, 0xA2, 0xA3 last), FIFO never full -> 1 idle cycle, then 3 consecutive writes {2,0,A1}, {2,0,A2}, {2,1,A3}; busy=1 for 3 cycles; rr_ptr=3.
- Fairness: all 4 requesting 1-beat packets continuously from reset -> grant order 0,1,2,3,0,…; each write separated by 1 bubble.
- Backpressure: fifo_wfull=1 for cycles 2–5 of a 4-beat packet from req 1 -> no fifo_wen or req_ready during full; all 4 beats are written in order with no duplicates.
- Overlong packet: MAX_BEATS=4, req 0 streams 6 beats with last only on beat 6 -> beat 4 is written with last=1 and err_overlong=1; the next grant resumes req 0 (if no others) with beats 5–6.
- Mask and mid-packet disable: req_en[1]=0 while req 1 is valid -> req 1 is never granted. Separately, clearing req_en[3] mid-packet -> packet from req 3 still completes.
- Reset mid-packet: assert reset during beat 2 of 4 -> fifo_wen=0 and busy=0 immediately; after release, arbitration restarts from rr_ptr=0.
